// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the POS-L3 packet TX arbitration path.
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_XFER)
//   DATA_W      : width of one data beat
//   MOD_W       : width of the byte modulus field
//   NUM_SRC     : number of packet sources feeding the arbiter
//   tx_mod_sel  : modulus presented to the MAC for a given beat
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

    localparam int DATA_W  = 64;
    localparam int MOD_W   = 3;
    localparam int NUM_SRC = 2;

    // Only the last beat of a packet carries a meaningful modulus; every other
    // beat is a full word and is sent with a zero modulus.
    function automatic logic [MOD_W-1:0] tx_mod_sel(input logic             eop,
                                                    input logic [MOD_W-1:0] mod);
        return eop ? mod : '0;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Combinational two-way round-robin winner selection.
// Ports:
//   candidates [1:0] in  : sources requesting ownership this cycle
//   rr_ptr           in  : preferred source when both request
//   winner     [1:0] out : one-hot winner, 00 when nobody requests
// ---------------------------------------------------------------------------
module arb_rr2
    import mac_pkg::*;
(
    input  logic [NUM_SRC-1:0] candidates,
    input  logic               rr_ptr,
    output logic [NUM_SRC-1:0] winner
);

    always_comb begin
        winner = candidates;
        // A tie is the only case needing the pointer; single requests win outright.
        if (candidates == 2'b11) begin
            winner = rr_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pkt_tx_arbiter
// Arbitrates two packet sources onto a single POS-L3 TX interface toward the
// MAC. Ownership is granted per packet (sop to eop) with round-robin fairness
// on ties, and each accepted beat is forwarded one cycle later.
// Ports:
//   clk_156m25       in  : sole clock, rising edge
//   reset_156m25_n   in  : asynchronous active-low reset
//   src_val/sop/eop  in  : per-source beat controls (bit i = source i)
//   src_mod          in  : per-source modulus, source i on [3i+2:3i]
//   src_data         in  : per-source data, source i on [64i+63:64i]
//   src_rdy          out : per-source ready, beat moves on val & rdy
//   pkt_tx_full      in  : MAC TX FIFO full, stalls the current owner
//   pkt_tx_val/sop/eop/mod/data out : registered POS-L3 TX to the MAC
//   grant            out : one-hot owner of the TX interface
//   pkt_cnt0/1       out : completed packets per source, wraps
//   proto_err        out : per-source one-cycle protocol violation pulse
// ---------------------------------------------------------------------------
module pkt_tx_arbiter
    import mac_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic                       clk_156m25,
    input  logic                       reset_156m25_n,
    input  logic [NUM_SRC-1:0]         src_val,
    input  logic [NUM_SRC-1:0]         src_sop,
    input  logic [NUM_SRC-1:0]         src_eop,
    input  logic [NUM_SRC*MOD_W-1:0]   src_mod,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    output logic [NUM_SRC-1:0]         src_rdy,
    input  logic                       pkt_tx_full,
    output logic                       pkt_tx_val,
    output logic                       pkt_tx_sop,
    output logic                       pkt_tx_eop,
    output logic [MOD_W-1:0]           pkt_tx_mod,
    output logic [DATA_W-1:0]          pkt_tx_data,
    output logic [NUM_SRC-1:0]         grant,
    output logic [CNT_W-1:0]           pkt_cnt0,
    output logic [CNT_W-1:0]           pkt_cnt1,
    output logic [NUM_SRC-1:0]         proto_err
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    arb_state_e          state_q;
    logic [NUM_SRC-1:0]  grant_q;
    logic                rr_ptr_q;
    logic                first_q;     // next forwarded beat opens the packet

    logic                tx_val_q;
    logic                tx_sop_q;
    logic                tx_eop_q;
    logic [MOD_W-1:0]    tx_mod_q;
    logic [DATA_W-1:0]   tx_data_q;

    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;
    logic [NUM_SRC-1:0]  proto_err_q, proto_err_d;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [NUM_SRC-1:0]  cand;
    logic [NUM_SRC-1:0]  winner;

    assign cand = src_val & src_sop;

    arb_rr2 u_arb_rr2 (
        .candidates (cand),
        .rr_ptr     (rr_ptr_q),
        .winner     (winner)
    );

    // -----------------------------------------------------------------------
    // Ready / transfer qualification
    // -----------------------------------------------------------------------
    logic [NUM_SRC-1:0]  rdy_raw;
    logic [NUM_SRC-1:0]  xfer;

    always_comb begin
        rdy_raw = '0;
        if (state_q == ARB_IDLE) begin
            // Non-sop beats arriving with no owner are swallowed so a broken
            // source cannot wedge itself; the sop beat waits for its grant.
            rdy_raw = src_val & ~src_sop;
        end else begin
            rdy_raw = grant_q & {NUM_SRC{~pkt_tx_full}};
        end
    end

    // Ready is combinational, so it is gated by reset to read 0 immediately.
    assign src_rdy = rdy_raw & {NUM_SRC{reset_156m25_n}};
    assign xfer    = src_val & src_rdy;

    // Owner beat mux: grant is one-hot, so its upper bit names the owner.
    logic                own_idx;
    logic                beat_sop;
    logic                beat_eop;
    logic [MOD_W-1:0]    beat_mod;
    logic [DATA_W-1:0]   beat_data;
    logic                beat_xfer;
    logic                dup_sop;
    logic                fwd;
    logic                pkt_done;

    assign own_idx   = grant_q[1];
    assign beat_sop  = own_idx ? src_sop[1] : src_sop[0];
    assign beat_eop  = own_idx ? src_eop[1] : src_eop[0];
    assign beat_mod  = own_idx ? src_mod[2*MOD_W-1:MOD_W]    : src_mod[MOD_W-1:0];
    assign beat_data = own_idx ? src_data[2*DATA_W-1:DATA_W] : src_data[DATA_W-1:0];

    assign beat_xfer = (state_q == ARB_XFER) && (|xfer);
    // A second sop inside an owned packet is consumed but never forwarded,
    // so it cannot terminate or restart the packet on the MAC side.
    assign dup_sop   = beat_xfer && beat_sop && !first_q;
    assign fwd       = beat_xfer && !dup_sop;
    assign pkt_done  = fwd && beat_eop;

    always_comb begin
        proto_err_d = '0;
        if (state_q == ARB_IDLE) begin
            proto_err_d = xfer;
        end else if (dup_sop) begin
            proto_err_d = grant_q;
        end
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pkt_done && !own_idx) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (pkt_done && own_idx) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|cand) begin
                        state_q <= ARB_XFER;
                        grant_q <= winner;
                        first_q <= 1'b1;
                    end
                end
                ARB_XFER: begin
                    if (fwd) begin
                        first_q <= 1'b0;
                    end
                    if (pkt_done) begin
                        state_q  <= ARB_IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= ~own_idx;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // TX output register, counters, error pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            tx_val_q    <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_mod_q    <= '0;
            tx_data_q   <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            proto_err_q <= '0;
        end else begin
            tx_val_q    <= fwd;
            tx_sop_q    <= fwd && first_q;
            tx_eop_q    <= fwd && beat_eop;
            // Data and modulus hold between beats; only controls drop to 0.
            if (fwd) begin
                tx_mod_q  <= tx_mod_sel(beat_eop, beat_mod);
                tx_data_q <= beat_data;
            end
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign pkt_tx_val  = tx_val_q;
    assign pkt_tx_sop  = tx_sop_q;
    assign pkt_tx_eop  = tx_eop_q;
    assign pkt_tx_mod  = tx_mod_q;
    assign pkt_tx_data = tx_data_q;
    assign grant       = grant_q;
    assign pkt_cnt0    = cnt0_q;
    assign pkt_cnt1    = cnt1_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pkt_tx_arbiter
// Scoreboard bench for pkt_tx_arbiter: per-source beat queues drive the
// inputs, accepted beats push their expected TX image, and the TX side pops
// and compares.
// ---------------------------------------------------------------------------
module tb_pkt_tx_arbiter;
    import mac_pkg::*;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MOD_W-1:0]  mod;
        logic              sop;
        logic              eop;
        logic              fwd;
        logic              xsop;
    } beat_t;

    logic              clk_156m25 = 1'b0;
    logic              reset_156m25_n;
    logic [1:0]        src_val, src_sop, src_eop, src_rdy;
    logic [5:0]        src_mod;
    logic [127:0]      src_data;
    logic              pkt_tx_full;
    logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]        pkt_tx_mod;
    logic [63:0]       pkt_tx_data;
    logic [1:0]        grant, proto_err;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

    always #5 clk_156m25 = ~clk_156m25;

    pkt_tx_arbiter #(.CNT_W(CNT_W)) u_dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .src_val        (src_val),
        .src_sop        (src_sop),
        .src_eop        (src_eop),
        .src_mod        (src_mod),
        .src_data       (src_data),
        .src_rdy        (src_rdy),
        .pkt_tx_full    (pkt_tx_full),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .pkt_tx_data    (pkt_tx_data),
        .grant          (grant),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1),
        .proto_err      (proto_err)
    );

    beat_t       sq0[$];
    beat_t       sq1[$];
    beat_t       exp_q[$];
    int          vcyc[$];
    logic [1:0]  owners[$];

    int          n_assert   = 0;
    int          n_fail     = 0;
    int          cyc        = 0;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          bad_grant  = 0;
    int          pkt_id     = 0;
    int          err_exp[2];
    int          err_seen[2];
    logic [1:0]  prev_grant = 2'b00;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_src(input int s, input beat_t b);
        if (s == 0) sq0.push_back(b);
        else        sq1.push_back(b);
    endtask

    // dup_at >= 0 inserts a dropped sop beat before beat index dup_at.
    task automatic add_pkt(input int s, input int nbeats, input logic [2:0] mod, input int dup_at);
        beat_t b;
        pkt_id++;
        for (int i = 0; i < nbeats; i++) begin
            if (i == dup_at) begin
                b.data = {8'hDD, 24'(pkt_id), 32'(i)};
                b.mod  = 3'd7;
                b.sop  = 1'b1;
                b.eop  = 1'b0;
                b.fwd  = 1'b0;
                b.xsop = 1'b0;
                push_src(s, b);
            end
            b.data = {8'(160 + s), 24'(pkt_id), 32'(i)};
            b.mod  = mod;
            b.sop  = (i == 0);
            b.eop  = (i == nbeats - 1);
            b.fwd  = 1'b1;
            b.xsop = (i == 0);
            push_src(s, b);
        end
    endtask

    task automatic add_stray(input int s);
        beat_t b;
        b.data = 64'hBAD0_BAD0_BAD0_BAD0;
        b.mod  = 3'd3;
        b.sop  = 1'b0;
        b.eop  = 1'b0;
        b.fwd  = 1'b0;
        b.xsop = 1'b0;
        push_src(s, b);
    endtask

    task automatic take(input int s, input beat_t b);
        beat_t e;
        if (b.fwd) begin
            e      = b;
            e.mod  = b.eop ? b.mod : 3'd0;
            e.sop  = b.xsop;
            exp_q.push_back(e);
        end else begin
            err_exp[s]++;
        end
    endtask

    // One clock: drive at posedge+1, observe and accept at negedge.
    task automatic cycle_step();
        beat_t b;
        beat_t e;
        src_val = 2'b00;
        src_sop = 2'b00;
        src_eop = 2'b00;
        if (sq0.size() > 0) begin
            b = sq0[0];
            src_val[0] = 1'b1; src_sop[0] = b.sop; src_eop[0] = b.eop;
            src_mod[2:0] = b.mod; src_data[63:0] = b.data;
        end
        if (sq1.size() > 0) begin
            b = sq1[0];
            src_val[1] = 1'b1; src_sop[1] = b.sop; src_eop[1] = b.eop;
            src_mod[5:3] = b.mod; src_data[127:64] = b.data;
        end
        pkt_tx_full = 1'b0;
        if (stall_left > 0 && sq0.size() == 3) begin
            pkt_tx_full = 1'b1;
            stall_left--;
        end
        @(negedge clk_156m25);
        if (pkt_tx_val) begin
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_beat", 64'(pkt_tx_val), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk_eq("tx_data", pkt_tx_data, e.data);
                chk_eq("tx_mod",  64'(pkt_tx_mod), 64'(e.mod));
                chk_eq("tx_sop",  64'(pkt_tx_sop), 64'(e.sop));
                chk_eq("tx_eop",  64'(pkt_tx_eop), 64'(e.eop));
            end
        end
        err_seen[0] += int'(proto_err[0]);
        err_seen[1] += int'(proto_err[1]);
        if (grant == 2'b11) bad_grant++;
        if (grant != 2'b00 && prev_grant == 2'b00) owners.push_back(grant);
        prev_grant = grant;
        if (pkt_tx_full) begin
            stall_seen++;
            chk_eq("stall_rdy",   64'(src_rdy), 64'd0);
            chk_eq("stall_grant", 64'(grant),   64'd1);
        end
        if (src_val[0] && src_rdy[0]) begin b = sq0.pop_front(); take(0, b); end
        if (src_val[1] && src_rdy[1]) begin b = sq1.pop_front(); take(1, b); end
        cyc++;
        @(posedge clk_156m25);
        #1;
    endtask

    task automatic run_idle(input int max_cyc);
        int n = 0;
        while ((sq0.size() > 0 || sq1.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
            cycle_step();
            n++;
        end
        chk_eq("run_pending", 64'(sq0.size() + sq1.size() + exp_q.size()), 64'd0);
        cycle_step();
        cycle_step();
    endtask

    task automatic check_reset_outputs();
        chk_eq("rst_src_rdy",   64'(src_rdy), 64'd0);
        chk_eq("rst_grant",     64'(grant), 64'd0);
        chk_eq("rst_tx_ctrl",   64'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}), 64'd0);
        chk_eq("rst_tx_data",   pkt_tx_data, 64'd0);
        chk_eq("rst_cnt",       64'({pkt_cnt0, pkt_cnt1}), 64'd0);
        chk_eq("rst_proto_err", 64'(proto_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int guard;
        err_exp  = '{0, 0};
        err_seen = '{0, 0};
        reset_156m25_n = 1'b0;
        src_val = '0; src_sop = '0; src_eop = '0;
        src_mod = '0; src_data = '0; pkt_tx_full = 1'b0;
        repeat (2) @(posedge clk_156m25);
        #1;
        // Stray non-sop beats must not raise ready while reset is held.
        src_val = 2'b11;
        #1;
        check_reset_outputs();
        src_val = 2'b00;
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        @(posedge clk_156m25);
        #1;

        // Contention: both sources always have a sop ready.
        owners.delete();
        for (int p = 0; p < 2; p++) begin
            add_pkt(0, 2, 3'd2, -1);
            add_pkt(1, 2, 3'd6, -1);
        end
        run_idle(100);
        chk_eq("owner_count", 64'(owners.size()), 64'd4);
        for (int i = 0; i < owners.size(); i++) begin
            chk_eq("owner_order", 64'(owners[i]), (i % 2 == 1) ? 64'd2 : 64'd1);
        end
        chk_eq("grant_onehot", 64'(bad_grant), 64'd0);
        chk_eq("cnt0_contention", 64'(pkt_cnt0), 64'd2);
        chk_eq("cnt1_contention", 64'(pkt_cnt1), 64'd2);

        // Single source, 3 beats, eop mod 5.
        vcyc.delete();
        c0 = cyc;
        add_pkt(0, 3, 3'd5, -1);
        run_idle(50);
        chk_eq("single_beats", 64'(vcyc.size()), 64'd3);
        if (vcyc.size() == 3) begin
            chk_eq("single_latency", 64'(vcyc[0] - c0), 64'd2);
            chk_eq("single_burst",   64'(vcyc[2] - vcyc[0]), 64'd2);
        end
        chk_eq("cnt0_single", 64'(pkt_cnt0), 64'd3);

        // Backpressure: full for 4 cycles on beat 2 of a 4-beat packet.
        vcyc.delete();
        stall_seen = 0;
        add_pkt(0, 4, 3'd3, -1);
        stall_left = 4;
        run_idle(50);
        chk_eq("stall_cycles", 64'(stall_seen), 64'd4);
        chk_eq("stall_beats",  64'(vcyc.size()), 64'd4);
        if (vcyc.size() == 4) begin
            chk_eq("stall_gap12", 64'(vcyc[1] - vcyc[0]), 64'd5);
            chk_eq("stall_gap23", 64'(vcyc[2] - vcyc[1]), 64'd1);
            chk_eq("stall_gap34", 64'(vcyc[3] - vcyc[2]), 64'd1);
        end
        chk_eq("cnt0_stall", 64'(pkt_cnt0), 64'd4);

        // Protocol errors: stray beat while idle, then duplicate sop mid-packet.
        vcyc.delete();
        add_stray(1);
        run_idle(20);
        chk_eq("stray_err1",  64'(err_seen[1]), 64'd1);
        chk_eq("stray_noval", 64'(vcyc.size()), 64'd0);
        add_pkt(0, 3, 3'd1, 1);
        run_idle(50);
        chk_eq("dup_err0",  64'(err_seen[0]), 64'd1);
        chk_eq("dup_beats", 64'(vcyc.size()), 64'd3);
        chk_eq("cnt0_dup",  64'(pkt_cnt0), 64'd5);

        // Reset after beat 2 of a 4-beat packet.
        add_pkt(0, 4, 3'd4, -1);
        guard = 0;
        while (sq0.size() > 2 && guard < 50) begin
            cycle_step();
            guard++;
        end
        chk_eq("midpkt_reached", 64'(sq0.size()), 64'd2);
        reset_156m25_n = 1'b0;
        src_val = 2'b11; src_sop = 2'b00; src_eop = 2'b00; pkt_tx_full = 1'b0;
        #1;
        check_reset_outputs();
        sq0.delete();
        exp_q.delete();
        prev_grant = 2'b00;
        @(negedge clk_156m25);
        src_val = 2'b00;
        #1;
        reset_156m25_n = 1'b1;
        @(posedge clk_156m25);
        #1;
        vcyc.delete();
        add_pkt(1, 2, 3'd7, -1);
        run_idle(50);
        chk_eq("postrst_beats", 64'(vcyc.size()), 64'd2);
        chk_eq("postrst_cnt1",  64'(pkt_cnt1), 64'd1);
        chk_eq("postrst_cnt0",  64'(pkt_cnt0), 64'd0);

        // Counter wrap at CNT_W = 4.
        for (int p = 0; p < 15; p++) add_pkt(0, 1, 3'd5, -1);
        run_idle(200);
        chk_eq("cnt0_15", 64'(pkt_cnt0), 64'd15);
        add_pkt(0, 1, 3'd5, -1);
        run_idle(20);
        chk_eq("cnt0_wrap", 64'(pkt_cnt0), 64'd0);

        chk_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk_eq("err_total0", 64'(err_seen[0]), 64'(err_exp[0]));
        chk_eq("err_total1", 64'(err_seen[1]), 64'(err_exp[1]));
        chk_eq("grant_onehot_all", 64'(bad_grant), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_tx_arbiter.md
PKT_TX_ARBITER -- requirements
Module: pkt_tx_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of each per-source packet counter.
REQ-002 Port clk_156m25  in  1  sole clock; every register is clocked on its rising edge.
REQ-003 Port reset_156m25_n  in  1  asynchronous, active-low reset.
REQ-004 Port src_val  in  2  per-source beat valid; bit i belongs to source i.
REQ-005 Port src_sop  in  2  per-source start-of-packet flag.
REQ-006 Port src_eop  in  2  per-source end-of-packet flag.
REQ-007 Port src_mod  in  6  per-source byte modulus; source i uses bits [3i+2:3i].
REQ-008 Port src_data  in  128  per-source 64-bit data; source i uses bits [64i+63:64i].
REQ-009 Port src_rdy  out  2  per-source ready; a beat transfers when src_val[i] and src_rdy[i] are both high.
REQ-010 Port pkt_tx_full  in  1  MAC TX FIFO full indication.
REQ-011 Ports pkt_tx_val, pkt_tx_sop, pkt_tx_eop  out  1 each  POS-L3 TX controls driven to the MAC.
REQ-012 Port pkt_tx_mod  out  3  POS-L3 TX modulus.
REQ-013 Port pkt_tx_data  out  64  POS-L3 TX data.
REQ-014 Port grant  out  2  one-hot owner of the TX interface; 00 when no source owns it.
REQ-015 Ports pkt_cnt0, pkt_cnt1  out  CNT_W each  number of packets completed per source.
REQ-016 Port proto_err  out  2  per-source one-cycle pulse flagging a protocol violation.

Function
REQ-017 The arbiter SHALL implement a two-state FSM.
- ARB_IDLE: grant is 00.
- ARB_XFER: exactly one grant bit is high.
REQ-018 In ARB_IDLE the arbiter SHALL choose among sources presenting src_val&src_sop.
- Only one candidate: that source wins.
- Both candidate: the source selected by the round-robin pointer rr_ptr wins.
- On the next edge: grant is set to the winner and the FSM moves to ARB_XFER.
- No beat transfers in the arbitration cycle.
REQ-019 In ARB_IDLE, src_rdy[i] SHALL equal src_val[i]&~src_sop[i].
- This flushes the stray beat; proto_err[i] pulses on the next cycle and nothing is forwarded.
REQ-020 In ARB_XFER, src_rdy[i] SHALL equal grant[i]&~pkt_tx_full, combinational with pkt_tx_full.
REQ-021 Each transferred beat of the owner SHALL appear one cycle later on pkt_tx_* with pkt_tx_val=1 for exactly one cycle.
- pkt_tx_mod = src_mod on eop beats, 000 on all other beats.
REQ-022 The first beat of an owned packet SHALL be forwarded with pkt_tx_sop=1.
- A later beat carrying sop=1 is accepted and dropped (not forwarded), and proto_err[i] pulses.
REQ-023 When a beat with eop=1 transfers, the arbiter SHALL:
- return the FSM to ARB_IDLE;
- clear grant;
- set rr_ptr to the other source;
- increment that source's counter.
REQ-024 A beat with sop=1 and eop=1 SHALL be forwarded as a complete single-beat packet.
REQ-025 Packet counters SHALL increment modulo 2^CNT_W, wrapping from all-ones to zero.
REQ-026 When no beat transfers, pkt_tx_val, pkt_tx_sop and pkt_tx_eop SHALL be 0 on the following cycle.
- pkt_tx_data and pkt_tx_mod hold their last values.
REQ-027 pkt_tx_full asserted for any duration mid-packet SHALL stall the owner without losing or duplicating beats, and grant SHALL hold.

Reset
REQ-028 While reset_156m25_n is low, the block SHALL immediately:
- force the FSM to ARB_IDLE;
- set rr_ptr to source 0;
- drive all outputs to 0 (grant=00, pkt_tx_*=0, counters=0, proto_err=00, src_rdy=00).
REQ-029 Reset asserted mid-packet SHALL abandon the packet, and the first post-reset packet SHALL start with pkt_tx_sop=1.

Structure
REQ-030 The shared package mac_pkg SHALL hold:
- enum arb_state_e {ARB_IDLE, ARB_XFER};
- constants DATA_W=64, MOD_W=3, NUM_SRC=2.
REQ-031 The winner selection SHALL be a combinational sub-module, arb_rr2 (inputs: candidates[1:0], rr_ptr; output: one-hot winner[1:0]).
- Everything else lives in pkt_tx_arbiter.

Verification
REQ-032 Single source: source 0 sends a 3-beat packet with eop mod=5 and pkt_tx_full=0.
- pkt_tx_val is high for 3 consecutive cycles starting 2 cycles after the sop beat is presented.
- sop is on beat 1, eop with mod=5 is on beat 3.
- pkt_cnt0 becomes 1.
REQ-033 Contention: both sources hold sop continuously, each sending 2-beat packets.
- Packet owners alternate 0,1,0,1.
- grant is never 11.
- After 4 packets, pkt_cnt0=2 and pkt_cnt1=2.
REQ-034 Backpressure: pkt_tx_full=1 for 4 cycles on beat 2 of a 4-beat packet.
- src_rdy is 0 for those 4 cycles.
- 4 beats are forwarded in order with no gaps other than the stall.
REQ-035 Protocol errors:
- A non-sop beat from source 1 while idle: proto_err[1] pulses once and pkt_tx_val stays 0.
- A second sop from the owner mid-packet: that beat is dropped and proto_err pulses.
REQ-036 Reset mid-packet after beat 2: all outputs read 0 during reset, and the next packet from source 1 is forwarded with correct sop.
REQ-037 Counter wrap with CNT_W=4: after 16 packets from source 0, pkt_cnt0 reads 0.
